hub75_frame_buffer: RTL and testbench

- Double-buffered pixel store that sits directly upstream of the HUB75 row scanner.
- Game logic writes single pixels, or issues a bulk clear, into the back buffer.
- The scanner reads the front buffer one column per request, getting the upper-half and lower-half pixel together to drive R0/G0/B0 and R1/G1/B1.
- Buffer swap happens only at the frame boundary the scanner reports, so the panel never shows a torn frame.

---
 rtl/hub75_frame_buffer.sv | 166 ++++++++++++++++
 tb/tb_hub75_frame_buffer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hub75_frame_buffer.sv
// HUB75 pixel store: back-buffer writes and bulk clear, front-buffer column reads.
// Define HUB75_FB_DOUBLE_BUF_EN for two buffers with a tear-free frame-boundary swap.
module hub75_frame_buffer #(
  parameter int COLS = 64,
  parameter int ROWS = 32,
  parameter int XW   = 6,
  parameter int YW   = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [XW-1:0] wr_x,
  input  logic [YW-1:0] wr_y,
  input  logic [2:0]    wr_rgb,
  input  logic          clr_start,
  input  logic [2:0]    clr_rgb,
  output logic          clr_busy,
  input  logic          swap_req,
  output logic          swap_pending,
  output logic          swap_ack,
  input  logic          frame_done,
  input  logic          rd_en,
  input  logic [YW-2:0] rd_row,
  input  logic [XW-1:0] rd_col,
  output logic          rd_valid,
  output logic [2:0]    rd_top_rgb,
  output logic [2:0]    rd_bot_rgb,
  output logic          front_sel
);

  localparam int HALF  = ROWS / 2;
  localparam int DEPTH = COLS * HALF;
  localparam int AW    = $clog2(DEPTH);
`ifdef HUB75_FB_DOUBLE_BUF_EN
  localparam int NBUF  = 2;
`else
  localparam int NBUF  = 1;
`endif
  localparam int MW    = $clog2(NBUF * DEPTH);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t state;

  logic [AW-1:0] clr_addr;
  logic [2:0]    clr_col;

  logic [2:0] mem_top [NBUF*DEPTH];
  logic [2:0] mem_bot [NBUF*DEPTH];

  logic          wr_ok;
  logic          wr_bot;
  logic [YW-1:0] wr_pair;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] mem_addr;
  logic [MW-1:0] mem_idx;
  logic [MW-1:0] rd_idx;
  logic [2:0]    mem_data;
  logic          clearing;
  logic          top_we;
  logic          bot_we;
  logic          rd_in;
  logic          do_swap;

  always_comb begin
    clearing = (state == CLEAR);
    wr_bot   = (wr_y >= YW'(HALF));
    wr_pair  = wr_bot ? (wr_y - YW'(HALF)) : wr_y;
    wr_addr  = AW'(wr_pair) * AW'(COLS) + AW'(wr_x);
    wr_ok    = wr_en & ~clr_busy
             & ({1'b0, wr_x} < (XW+1)'(COLS))
             & ({1'b0, wr_y} < (YW+1)'(ROWS));
    top_we   = clearing | (wr_ok & ~wr_bot);
    bot_we   = clearing | (wr_ok & wr_bot);
    mem_addr = clearing ? clr_addr : wr_addr;
    mem_data = clearing ? clr_col : wr_rgb;
    rd_addr  = AW'(rd_row) * AW'(COLS) + AW'(rd_col);
    rd_in    = ({1'b0, rd_col} < (XW+1)'(COLS));
  end

`ifdef HUB75_FB_DOUBLE_BUF_EN
  assign mem_idx = {~front_sel, mem_addr};
  assign rd_idx  = {front_sel, rd_addr};
  assign do_swap = frame_done & (swap_pending | swap_req) & ~clr_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      front_sel <= 1'b0;
    end else if (do_swap) begin
      front_sel <= ~front_sel;
    end
  end
`else
  logic unused_frame_done;

  // Single buffer: nothing to tear, so acks only wait out a clear
  assign unused_frame_done = frame_done;
  assign mem_idx   = mem_addr;
  assign rd_idx    = rd_addr;
  assign do_swap   = (swap_pending | swap_req) & ~clr_busy;
  assign front_sel = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      clr_busy <= 1'b0;
      clr_addr <= '0;
      clr_col  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (clr_start) begin
            state    <= CLEAR;
            clr_busy <= 1'b1;
            clr_addr <= '0;
            clr_col  <= clr_rgb;
          end
        end
        CLEAR: begin
          clr_addr <= clr_addr + AW'(1);
          if (clr_addr == AW'(DEPTH - 1)) begin
            state    <= IDLE;
            clr_busy <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (top_we) mem_top[mem_idx] <= mem_data;
    if (bot_we) mem_bot[mem_idx] <= mem_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid   <= 1'b0;
      rd_top_rgb <= '0;
      rd_bot_rgb <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_top_rgb <= rd_in ? mem_top[rd_idx] : 3'b000;
        rd_bot_rgb <= rd_in ? mem_bot[rd_idx] : 3'b000;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      swap_pending <= 1'b0;
      swap_ack     <= 1'b0;
    end else begin
      swap_ack <= do_swap;
      if (do_swap) swap_pending <= 1'b0;
      else if (swap_req) swap_pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hub75_frame_buffer.sv
// Directed bench for hub75_frame_buffer; read results checked via an expectation queue.
// Expectations follow HUB75_FB_DOUBLE_BUF_EN when it is defined.
module tb_hub75_frame_buffer;

  localparam int COLS = 64;
  localparam int ROWS = 32;
  localparam int XW   = 6;
  localparam int YW   = 5;
`ifdef HUB75_FB_DOUBLE_BUF_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [XW-1:0] wr_x = '0;
  logic [YW-1:0] wr_y = '0;
  logic [2:0]    wr_rgb = '0;
  logic          clr_start = 1'b0;
  logic [2:0]    clr_rgb = '0;
  logic          clr_busy;
  logic          swap_req = 1'b0;
  logic          swap_pending;
  logic          swap_ack;
  logic          frame_done = 1'b0;
  logic          rd_en = 1'b0;
  logic [YW-2:0] rd_row = '0;
  logic [XW-1:0] rd_col = '0;
  logic          rd_valid;
  logic [2:0]    rd_top_rgb;
  logic [2:0]    rd_bot_rgb;
  logic          front_sel;

  int total = 0;
  int bad = 0;
  logic [5:0] exp_q [$];
  logic exp_front = 1'b0;
  int n;

  always #5 clk = ~clk;

  hub75_frame_buffer #(
    .COLS(COLS), .ROWS(ROWS), .XW(XW), .YW(YW)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_rgb(wr_rgb),
    .clr_start(clr_start), .clr_rgb(clr_rgb), .clr_busy(clr_busy),
    .swap_req(swap_req), .swap_pending(swap_pending),
    .swap_ack(swap_ack), .frame_done(frame_done),
    .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col),
    .rd_valid(rd_valid), .rd_top_rgb(rd_top_rgb),
    .rd_bot_rgb(rd_bot_rgb), .front_sel(front_sel)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    logic issued;
    logic [5:0] e;
    issued = rd_en;
    @(posedge clk);
    #1;
    if (issued && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("rd_valid", 32'(rd_valid), 1);
      chk("rd_top", 32'(rd_top_rgb), 32'(e[5:3]));
      chk("rd_bot", 32'(rd_bot_rgb), 32'(e[2:0]));
    end else if (!rst) begin
      chk("rd_valid_idle", 32'(rd_valid), 0);
    end
  endtask

  task automatic wr(input int x, input int y, input logic [2:0] c);
    wr_en = 1'b1;
    wr_x = XW'(x);
    wr_y = YW'(y);
    wr_rgb = c;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic issue(input int r, input int c,
                       input logic [2:0] t, input logic [2:0] b);
    rd_en = 1'b1;
    rd_row = (YW-1)'(r);
    rd_col = XW'(c);
    exp_q.push_back({t, b});
  endtask

  task automatic rd1(input int r, input int c,
                     input logic [2:0] t, input logic [2:0] b);
    issue(r, c, t, b);
    tick();
    rd_en = 1'b0;
  endtask

  task automatic swap_fd();
    swap_req = 1'b1;
    frame_done = 1'b1;
    tick();
    swap_req = 1'b0;
    frame_done = 1'b0;
    exp_front = exp_front ^ DB;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_front", 32'(front_sel), 0);
    chk("rst_pend", 32'(swap_pending), 0);
    chk("rst_ack", 32'(swap_ack), 0);
    chk("rst_busy", 32'(clr_busy), 0);
    chk("rst_valid", 32'(rd_valid), 0);
    chk("rst_top", 32'(rd_top_rgb), 0);
    chk("rst_bot", 32'(rd_bot_rgb), 0);
    rst = 1'b0;
    tick();

    wr(3, 5, 3'b101);
    wr(3, 21, 3'b010);
    swap_fd();
    chk("s1_ack", 32'(swap_ack), 1);
    chk("s1_front", 32'(front_sel), 32'(exp_front));
    chk("s1_pend", 32'(swap_pending), 0);
    rd1(5, 3, 3'b101, 3'b010);
    chk("s1_ack_lo", 32'(swap_ack), 0);

    wr(3, 5, 3'b011);
    wr(3, 21, 3'b110);
    rd1(5, 3, DB ? 3'b101 : 3'b011, DB ? 3'b010 : 3'b110);
    swap_fd();
    chk("s2_ack", 32'(swap_ack), 1);
    chk("s2_front", 32'(front_sel), 32'(exp_front));
    rd1(5, 3, 3'b011, 3'b110);

    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    chk("req_only_ack", 32'(swap_ack), 32'(!DB));
    chk("req_only_pend", 32'(swap_pending), 32'(DB));
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    exp_front = exp_front ^ DB;
    chk("fd_only_ack", 32'(swap_ack), 32'(DB));
    chk("fd_only_front", 32'(front_sel), 32'(exp_front));
    chk("fd_only_pend", 32'(swap_pending), 0);

    clr_rgb = 3'b111;
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    clr_rgb = 3'b000;
    n = 0;
    while (clr_busy && n < 2000) begin
      if (n == 600) begin
        wr_en = 1'b1; wr_x = 6'd3; wr_y = 5'd5; wr_rgb = 3'b000;
        swap_req = 1'b1; frame_done = 1'b1;
      end else if (n == 601) begin
        wr_en = 1'b0; swap_req = 1'b0; frame_done = 1'b0;
      end else if (n == 700) begin
        chk("mid_clr_pend", 32'(swap_pending), 1);
        chk("mid_clr_ack", 32'(swap_ack), 0);
        chk("mid_clr_front", 32'(front_sel), 32'(exp_front));
        clr_start = 1'b1;
      end else if (n == 701) begin
        clr_start = 1'b0;
      end
      n++;
      tick();
    end
    chk("clr_busy_cycles", n, 1024);
    chk("post_clr_pend", 32'(swap_pending), 1);
    chk("post_clr_ack0", 32'(swap_ack), 0);
    tick();
    chk("post_clr_ack", 32'(swap_ack), 32'(!DB));
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    exp_front = exp_front ^ DB;
    chk("post_clr_fd_ack", 32'(swap_ack), 32'(DB));
    chk("post_clr_front", 32'(front_sel), 32'(exp_front));
    chk("post_clr_pend0", 32'(swap_pending), 0);

    for (int r = 0; r < ROWS / 2; r++) begin
      for (int c = 0; c < COLS; c++) begin
        issue(r, c, 3'b111, 3'b111);
        tick();
      end
    end
    rd_en = 1'b0;
    tick();

    wr(63, 31, 3'b100);
    wr(63, 15, 3'b110);
    wr(0, 16, 3'b001);
    wr(0, 0, 3'b010);
    swap_fd();
    chk("corner_ack", 32'(swap_ack), 1);
    rd1(15, 63, 3'b110, 3'b100);
    rd1(0, 0, 3'b010, 3'b001);

    clr_rgb = 3'b111;
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    n = 0;
    while (n < 300) begin
      swap_req = (n == 10);
      n++;
      tick();
    end
    swap_req = 1'b0;
    chk("busy_before_rst", 32'(clr_busy), 1);
    chk("pend_before_rst", 32'(swap_pending), 1);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(clr_busy), 0);
    chk("arst_front", 32'(front_sel), 0);
    chk("arst_pend", 32'(swap_pending), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    clr_rgb = 3'b101;
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    n = 0;
    while (clr_busy && n < 2000) begin
      n++;
      tick();
    end
    chk("clr2_busy_cycles", n, 1024);
    rd1(0, 0, DB ? 3'b111 : 3'b101, DB ? 3'b111 : 3'b101);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
